// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC plus a small FIFO of {instruction, PC+4} feeding decode.
// Optional jump predecode is enabled with `define FETCH_JUMP_PREDECODE_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imemAddress,
    input  logic [31:0]              imemInstruction,
    input  logic                     redirect,
    input  logic [31:0]              redirectTarget,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [31:0]              outInstruction,
    output logic [31:0]              outPCPlus4,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    logic [31:0] fetch_pc, pc4, next_pc;
    logic [31:0] ibuf [DEPTH];
    logic [31:0] pbuf [DEPTH];
    logic [AW-1:0] rd, wr;
    logic push, pop;
    assign pc4 = fetch_pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
    assign next_pc = (imemInstruction[31:26] == 6'b000010) ? {pc4[31:28], imemInstruction[25:0], 2'b00} : pc4;
`else
    assign next_pc = pc4;
`endif
    assign imemAddress    = fetch_pc;
    assign outValid       = |count;
    assign outInstruction = outValid ? ibuf[rd] : 32'h0;
    assign outPCPlus4     = outValid ? pbuf[rd] : 32'h0;
    assign pop  = outValid & outReady;
    assign push = ~redirect & ((count < FULL) | pop);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd       <= '0;
            wr       <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirectTarget & 32'hFFFF_FFFC;
            rd       <= '0;
            wr       <= '0;
            count    <= '0;
        end else begin
            if (push) fetch_pc <= next_pc;
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
        end
    end
    // storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            ibuf[wr] <= imemInstruction;
            pbuf[wr] <= pc4;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    typedef struct packed { logic [31:0] i; logic [31:0] p; } ent_t;
    logic clk = 0, reset = 1;
    logic [31:0] imemAddress, imemInstruction, redirectTarget, outInstruction, outPCPlus4;
    logic redirect = 0, outReady = 0, outValid;
    logic [2:0] count;
    logic [31:0] a2, i2, oi2, op2;
    logic v2;
    logic [2:0] c2;
    int n = 0, fails = 0;
    ent_t q[$];
    logic [31:0] mpc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'd8) ? 32'h0800_0100 : a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    assign imemInstruction = mem(imemAddress);
    assign i2 = mem(a2);

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imemAddress(imemAddress), .imemInstruction(imemInstruction),
        .redirect(redirect), .redirectTarget(redirectTarget), .outValid(outValid), .outReady(outReady),
        .outInstruction(outInstruction), .outPCPlus4(outPCPlus4), .count(count));

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .imemAddress(a2), .imemInstruction(i2),
        .redirect(1'b0), .redirectTarget(32'h0), .outValid(v2), .outReady(1'b0),
        .outInstruction(oi2), .outPCPlus4(op2), .count(c2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        ent_t h = q.size() > 0 ? q[0] : '0;
        chk("imemAddress", imemAddress, mpc);
        chk("count", 32'(count), 32'(q.size()));
        chk("outValid", 32'(outValid), 32'(q.size() > 0));
        chk("outInstruction", outInstruction, h.i);
        chk("outPCPlus4", outPCPlus4, h.p);
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc);
        logic [31:0] ins = mem(pc);
        logic [31:0] p4 = pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (ins[31:26] == 6'b000010) return {p4[31:28], ins[25:0], 2'b00};
`endif
        return p4;
    endfunction

    task automatic cycle(input logic rdy, input logic rdr, input logic [31:0] tgt);
        bit pop;
        outReady = rdy;
        redirect = rdr;
        redirectTarget = tgt;
        pop = rdy && q.size() > 0;
        if (rdr) begin
            q.delete();
            mpc = {tgt[31:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                q.push_back({mem(mpc), mpc + 32'd4});
                mpc = model_next(mpc);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        redirect = 0;
        #1;
        q.delete();
        mpc = 32'h0;
        check_all();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        mpc = 0;
        @(negedge clk);
        check_all();
        chk("rst_pc2_addr", a2, 32'hFFFF_FFFC);
        chk("rst_pc2_count", 32'(c2), 0);
        @(negedge clk);
        reset = 0;
        cycle(1, 0, 0);
        chk("first_instr", outInstruction, mem(0));
        chk("first_pc4", outPCPlus4, 32'd4);
        chk("first_addr", imemAddress, 32'd4);
        chk("wrap_pc4", op2, 32'h0);
        chk("wrap_addr", a2, 32'h0);
        chk("wrap_valid", 32'(v2), 1);
        repeat (3) cycle(1, 0, 0);
        chk("stream_addr", imemAddress, 32'd16);
        do_reset();
        repeat (6) cycle(0, 0, 0);
        chk("sat_count", 32'(count), 4);
        chk("stall_addr", imemAddress, 32'd16);
        for (int k = 1; k <= 5; k++) begin
            chk("drain_pc4", outPCPlus4, 32'(4 * k));
            chk("full_count", 32'(count), 4);
            cycle(1, 0, 0);
        end
        chk("full_addr", imemAddress, 32'd36);
        do_reset();
        repeat (3) cycle(0, 0, 0);
        chk("pre_redirect_count", 32'(count), 3);
        cycle(1, 1, 32'h0000_0043);
        chk("redir_count", 32'(count), 0);
        chk("redir_valid", 32'(outValid), 0);
        chk("redir_addr", imemAddress, 32'h40);
        cycle(1, 0, 0);
        chk("redir_pc4", outPCPlus4, 32'h44);
        chk("redir_instr", outInstruction, mem(32'h40));
`ifdef FETCH_JUMP_PREDECODE_EN
        do_reset();
        repeat (3) cycle(0, 0, 0);
        chk("j_addr", imemAddress, 32'h400);
        cycle(0, 0, 0);
        repeat (2) cycle(1, 0, 0);
        chk("j_pc4", outPCPlus4, 32'd12);
        cycle(1, 0, 0);
        chk("j_tgt_instr", outInstruction, mem(32'h400));
        chk("j_tgt_pc4", outPCPlus4, 32'h404);
`endif
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
